// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode and FSM state definitions for the sliced bitwise logic unit
package logic_unit_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_AND   = 3'd0;
    localparam opcode_t OP_OR    = 3'd1;
    localparam opcode_t OP_XOR   = 3'd2;
    localparam opcode_t OP_NOR   = 3'd3;
    localparam opcode_t OP_ANDN  = 3'd4;
    localparam opcode_t OP_ORN   = 3'd5;
    localparam opcode_t OP_PASSA = 3'd6;
    localparam opcode_t OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_logic_seq_if.sv
// rtl/bitwise_logic_seq_if.sv - request/response handshake bundle for the sliced bitwise logic unit
interface bitwise_logic_seq_if #(
    parameter int WIDTH = 32
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    opcode_t          opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             result_zero;
    logic             busy;

    modport master (
        output in_valid, opcode, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, result_zero, busy
    );

    modport slave (
        input  in_valid, opcode, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, result_zero, busy
    );

endinterface

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - combinational opcode-selected bitwise operation on one slice
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  opcode_t          opcode,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (opcode)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_ANDN:  y = a & ~b;
            OP_ORN:   y = a | ~b;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_seq.sv
// rtl/bitwise_logic_seq.sv - multi-cycle bitwise logic unit, one slice per cycle, LSB slice first
module bitwise_logic_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                clock,
    input  logic                reset,
    bitwise_logic_seq_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state;
    state_t           state_nxt;
    opcode_t          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] y_sl;
    logic             last;

    assign last = (cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = BUSY;
            BUSY:    if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand slice select for the current counter position
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .opcode (op_q),
        .a      (a_sl),
        .b      (b_sl),
        .y      (y_sl)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= OP_AND;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.opcode;
                        a_q    <= bus.operand_a;
                        b_q    <= bus.operand_b;
                        res_q  <= '0;
                        zero_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (cnt == CW'(k)) begin
                            res_q[k*SLICE +: SLICE] <= y_sl;
                        end
                    end
                    // Running flag: ends up equal to ~|result once all slices land
                    zero_q <= zero_q & ~(|y_sl);
                    cnt    <= last ? '0 : cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.busy        = (state != IDLE);
    assign bus.result      = res_q;
    assign bus.result_zero = zero_q;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// tb/tb_bitwise_logic_seq.sv - directed vector bench for bitwise_logic_seq (SLICE=8 and SLICE=WIDTH)
module tb_bitwise_logic_seq;
    import logic_unit_pkg::*;

    logic clock;
    logic rst_a;
    logic rst_b;

    int tests;
    int fails;

    bitwise_logic_seq_if #(.WIDTH(32)) ia ();
    bitwise_logic_seq_if #(.WIDTH(32)) ib ();

    bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (ia.slave)
    );

    bitwise_logic_seq #(.WIDTH(32), .SLICE(32)) dut_b (
        .clock (clock),
        .reset (rst_b),
        .bus   (ib.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one op on dut_a from IDLE; returns result, flag and cycles from accept to out_valid
    task automatic run_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic zero, output int lat);
        ia.opcode    = op;
        ia.operand_a = a;
        ia.operand_b = b;
        ia.in_valid  = 1'b1;
        step();
        ia.in_valid = 1'b0;
        lat = 0;
        while (!ia.out_valid && lat < 20) begin
            step();
            lat++;
        end
        res  = ia.result;
        zero = ia.result_zero;
    endtask

    logic [31:0] r;
    logic        z;
    int          lat;
    int          bad;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{OP_OR,    32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0};
        vecs[1] = '{OP_XOR,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[2] = '{OP_NOR,   32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{OP_ANDN,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
        vecs[4] = '{OP_AND,   32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0};
        vecs[5] = '{OP_ORN,   32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0};
        vecs[6] = '{OP_PASSA, 32'hCAFE_BABE, 32'h1111_1111, 32'hCAFE_BABE, 1'b0};
        vecs[7] = '{OP_RSVD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[8] = '{OP_AND,   32'hFF00_0000, 32'h00FF_FFFF, 32'h0000_0000, 1'b1};
        vecs[9] = '{OP_XOR,   32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.in_valid = 1'b0; ia.opcode = OP_AND; ia.operand_a = '0; ia.operand_b = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.opcode = OP_AND; ib.operand_a = '0; ib.operand_b = '0; ib.out_ready = 1'b1;
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state held while idle
        for (int i = 0; i < 5; i++) begin
            check("reset_idle", {60'd0, ia.in_ready, ia.out_valid, ia.busy, ia.result_zero},
                  {60'd0, 4'b1000});
            check("reset_result", {32'd0, ia.result}, 64'd0);
            step();
        end

        // Vector table, out_ready tied high
        for (int i = 0; i < 10; i++) begin
            run_a(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
            check($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].res});
            check($sformatf("vec%0d_zero", i), {63'd0, z}, {63'd0, vecs[i].zero});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            step();
            check($sformatf("vec%0d_back_idle", i), {62'd0, ia.in_ready, ia.out_valid}, 64'd2);
        end

        // Backpressure: result held, new requests ignored
        ia.out_ready = 1'b0;
        run_a(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, r, z, lat);
        check("bp_result", {32'd0, r}, {32'd0, 32'h1D3B_5977});
        check("bp_latency", 64'(lat), 64'd4);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            ia.in_valid  = 1'b1;
            ia.opcode    = 3'(i);
            ia.operand_a = $urandom;
            ia.operand_b = $urandom;
            step();
            if ({ia.out_valid, ia.in_ready, ia.busy, ia.result_zero, ia.result} !==
                {4'b1010, 32'h1D3B_5977}) bad++;
        end
        check("bp_hold_cycles_bad", 64'(bad), 64'd0);
        ia.out_ready = 1'b1;
        step();
        ia.in_valid = 1'b0;
        check("bp_consume", {29'd0, ia.in_ready, ia.out_valid, ia.busy, ia.result},
              {29'd0, 3'b100, 32'h1D3B_5977});
        step();
        check("bp_no_same_cycle_accept", {62'd0, ia.in_ready, ia.busy}, 64'd2);

        // Operand/opcode churn after acceptance
        ia.opcode    = OP_AND;
        ia.operand_a = 32'hFFFF_0000;
        ia.operand_b = 32'h00FF_FF00;
        ia.in_valid  = 1'b1;
        step();
        ia.in_valid = 1'b0;
        lat = 0;
        while (!ia.out_valid && lat < 20) begin
            ia.opcode    = 3'($urandom_range(0, 7));
            ia.operand_a = $urandom;
            ia.operand_b = $urandom;
            step();
            lat++;
        end
        check("churn_result", {31'd0, ia.result_zero, ia.result}, {32'd0, 32'h00FF_0000});
        check("churn_latency", 64'(lat), 64'd4);
        step();

        // Reset during BUSY cycle 2
        ia.opcode    = OP_OR;
        ia.operand_a = 32'hFFFF_FFFF;
        ia.operand_b = 32'h0000_0000;
        ia.in_valid  = 1'b1;
        step();
        ia.in_valid = 1'b0;
        step();
        check("rst_partial", {32'd0, ia.result}, {32'd0, 32'h0000_00FF});
        rst_a = 1'b1;
        ia.in_valid = 1'b1;
        step();
        rst_a = 1'b0;
        ia.in_valid = 1'b0;
        check("rst_mid_busy", {28'd0, ia.in_ready, ia.out_valid, ia.busy, ia.result_zero, ia.result},
              {28'd0, 4'b1000, 32'd0});
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ia.out_valid !== 1'b0 || ia.busy !== 1'b0) bad++;
        end
        check("rst_no_out_valid", 64'(bad), 64'd0);

        // SLICE == WIDTH: single BUSY cycle
        ib.opcode    = OP_XOR;
        ib.operand_a = 32'hAAAA_5555;
        ib.operand_b = 32'hFFFF_0000;
        ib.in_valid  = 1'b1;
        step();
        ib.in_valid = 1'b0;
        lat = 0;
        while (!ib.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("full_latency", 64'(lat), 64'd1);
        check("full_result", {31'd0, ib.result_zero, ib.result}, {32'd0, 32'h5555_5555});
        step();
        check("full_back_idle", {62'd0, ib.in_ready, ib.out_valid}, 64'd2);

        ib.opcode    = OP_PASSA;
        ib.operand_a = 32'h1357_9BDF;
        ib.in_valid  = 1'b1;
        step();
        ib.in_valid = 1'b0;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        check("full_rst_busy", {28'd0, ib.in_ready, ib.out_valid, ib.busy, ib.result_zero, ib.result},
              {28'd0, 4'b1000, 32'd0});
        step();
        check("full_rst_stays_idle", {62'd0, ib.out_valid, ib.busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
